data_mem_responder: RTL

- Responder end of the core's load/store data port: accepts one request at a time over a valid/ready request channel and returns data/status over a valid/ready response channel.
- Backed by an internal word-organised RAM with byte-lane writes and RV32I load/store sizing selected by funct3.
- Programmable wait states let the core's multi-cycle memory path be exercised against realistic latency.

---
 rtl/riscv_pkg.sv | 64 ++++++
 rtl/dmem_ram.sv | 33 +++
 rtl/data_mem_responder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I load/store definitions: funct3 sizing codes, responder FSM
// encoding and the request record latched by the data-memory responder.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef struct packed {
        logic        write;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } memReq_t;

    // A request is rejected for bad alignment, an address past the RAM, or a size code
    // the direction does not support (stores have no unsigned variants).
    function automatic logic reqError(input memReq_t r, input logic [31:0] depthWords);
        logic misaligned;
        logic outOfRange;
        logic badFunct3;
        misaligned = ((r.funct3 == F3_H || r.funct3 == F3_HU) && r.addr[0]) ||
                     ((r.funct3 == F3_W) && (r.addr[1:0] != 2'b00));
        outOfRange = ({2'b00, r.addr[31:2]} >= depthWords);
        if (r.write) begin
            badFunct3 = !(r.funct3 inside {F3_B, F3_H, F3_W});
        end else begin
            badFunct3 = (r.funct3 inside {3'b011, 3'b110, 3'b111});
        end
        return misaligned || outOfRange || badFunct3;
    endfunction

    function automatic logic [31:0] loadExtend(input logic [31:0] word, input logic [2:0] funct3,
                                               input logic [1:0] lane);
        logic [31:0] shifted;
        logic [7:0]  byteVal;
        logic [15:0] halfVal;
        shifted = word >> {lane, 3'b000};
        byteVal = shifted[7:0];
        halfVal = lane[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    return {{24{byteVal[7]}}, byteVal};
            F3_H:    return {{16{halfVal[15]}}, halfVal};
            F3_BU:   return {24'd0, byteVal};
            F3_HU:   return {16'd0, halfVal};
            default: return word;
        endcase
    endfunction

    function automatic logic [3:0] storeLanes(input logic [2:0] funct3, input logic [1:0] lane);
        case (funct3)
            F3_B:    return 4'b0001 << lane;
            F3_H:    return lane[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-organised single-port RAM with per-byte write enables and a registered
// read port; the read register only updates on a read so it holds between accesses.
module dmem_ram #(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = 8
) (
    input  logic             clk,
    input  logic             en_i,
    input  logic [3:0]       we_i,
    input  logic [IDX_W-1:0] addr_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i == 4'b0000) begin
                rdata_q <= mem_q[addr_i];
            end
            for (int lane = 0; lane < 4; lane++) begin
                if (we_i[lane]) begin
                    mem_q[addr_i][lane*8 +: 8] <= wdata_i[lane*8 +: 8];
                end
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the core's load/store port: one request at a time, a programmable
// number of wait states, then a held response carrying load data or an error flag.
module data_mem_responder
    import riscv_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2,
    parameter int IDX_W       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        busy
);

    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    memReq_t          req_q, req_d;
    logic [31:0]      rdataHold_q, rdataHold_d;

    memReq_t     curReq;
    logic        accept;
    logic        accessEdge;
    logic        curErr;
    logic        ramEn;
    logic [3:0]  ramWe;
    logic [31:0] ramWdata;
    logic [31:0] ramRdata;
    logic [31:0] loadData;

    assign req_ready = (state_q == ST_IDLE) && reset;
    assign accept    = req_valid && req_ready;

    // With zero wait states the access shares the accept edge, so the live request
    // is used in IDLE and the latched copy everywhere else.
    always_comb begin
        curReq = req_q;
        if (state_q == ST_IDLE) begin
            curReq.write  = req_write;
            curReq.funct3 = req_funct3;
            curReq.addr   = req_addr;
            curReq.wdata  = req_wdata;
        end
    end

    assign curErr     = reqError(curReq, 32'(DEPTH_WORDS));
    assign accessEdge = reset && (((state_q == ST_WAIT) && (cnt_q == CNT_LAST)) ||
                                  ((WAIT_STATES == 0) && accept));

    // Loads read the RAM on the accept edge; no write can intervene before the response.
    assign ramWe    = (accessEdge && curReq.write && !curErr) ?
                      storeLanes(curReq.funct3, curReq.addr[1:0]) : 4'b0000;
    assign ramEn    = (accept && !req_write) || (ramWe != 4'b0000);
    assign ramWdata = (curReq.funct3 == F3_B) ? {4{curReq.wdata[7:0]}} :
                      (curReq.funct3 == F3_H) ? {2{curReq.wdata[15:0]}} : curReq.wdata;

    dmem_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_ram (
        .clk    (clk),
        .en_i   (ramEn),
        .we_i   (ramWe),
        .addr_i (curReq.addr[IDX_W+1:2]),
        .wdata_i(ramWdata),
        .rdata_o(ramRdata)
    );

    assign loadData  = ((state_q == ST_RESP) && !curReq.write && !curErr) ?
                       loadExtend(ramRdata, curReq.funct3, curReq.addr[1:0]) : 32'd0;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_error = (state_q == ST_RESP) && curErr;
    assign rsp_rdata = (state_q == ST_RESP) ? loadData : rdataHold_q;
    assign busy      = (state_q != ST_IDLE);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        rdataHold_d = rdataHold_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    req_d   = curReq;
                    cnt_d   = CNT_LOAD;
                    state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_LAST;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rdataHold_d = loadData;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            req_q       <= '0;
            rdataHold_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            rdataHold_q <= rdataHold_d;
        end
    end

endmodule
